// File: rtl/painel_pkg.sv
// ---------------------------------------------------------------------------
// painel_pkg
// Shared definitions for the front-panel input conditioner.
//   - Channel index constants for the seven panel inputs (sensor switches
//     sn/sr/sp, selection buttons b1/b0, value buttons v1/v0).
//   - Per-channel debounce state encoding.
//   - Default acceptance time (1 ms at 50 MHz).
//   - Polarity helper that maps a synchronized pin level to "1 = active".
// ---------------------------------------------------------------------------
package painel_pkg;

  // Bit positions of each panel input inside the raw/stable/rise/fall vectors.
  localparam int CH_SN = 0;
  localparam int CH_SR = 1;
  localparam int CH_SP = 2;
  localparam int CH_B1 = 3;
  localparam int CH_B0 = 4;
  localparam int CH_V1 = 5;
  localparam int CH_V0 = 6;

  localparam int N_CH_DEF = 7;

  // Cycles a new level must persist before it is accepted.
  localparam int DEB_CYCLES_DEF = 50000;

  // Per-channel debounce state.
  //   ST_IDLE  : synchronized level equals the accepted level.
  //   ST_COUNT : level differs, timing how long it has differed.
  //   ST_HELD  : accepted press with auto-repeat enabled, timing repeats.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } estado_t;

  // Convert a synchronized pin level into an active-high level.
  function automatic logic normaliza(input logic nivel, input bit active_low);
    return active_low ? ~nivel : nivel;
  endfunction

endpackage

// File: rtl/debounce_entradas_if.sv
// ---------------------------------------------------------------------------
// debounce_entradas_if
// Signal bundle between the raw panel pins and the machine FSMs.
//   raw       : asynchronous panel levels (pin polarity)
//   stable    : debounced level per channel, 1 = pressed/active
//   rise      : one-cycle pulse on accepted press and on each auto-repeat
//   fall      : one-cycle pulse on accepted release
//   any_rise  : OR of rise, same cycle
//   dbg_state : per-channel FSM state (painel_pkg::estado_t encoding)
//
// There is no valid/ready handshake on this bundle: raw is a free-running
// level, stable is a level, and rise/fall/any_rise are registered pulses that
// are exactly one clock wide; consumers must sample them every cycle and can
// never apply back-pressure.
//
// Modports:
//   master : the panel side / environment (drives raw, observes the rest)
//   slave  : the conditioner (reads raw, drives the rest)
// ---------------------------------------------------------------------------
interface debounce_entradas_if #(
  parameter int N_CH = 7
);

  logic [N_CH-1:0]      raw;
  logic [N_CH-1:0]      stable;
  logic [N_CH-1:0]      rise;
  logic [N_CH-1:0]      fall;
  logic                 any_rise;
  logic [N_CH-1:0][1:0] dbg_state;

  modport master (
    output raw,
    input  stable,
    input  rise,
    input  fall,
    input  any_rise,
    input  dbg_state
  );

  modport slave (
    input  raw,
    output stable,
    output rise,
    output fall,
    output any_rise,
    output dbg_state
  );

endinterface

// File: rtl/debounce_canal.sv
// ---------------------------------------------------------------------------
// debounce_canal
// One panel input channel: two-flop synchronizer, polarity normalization,
// debounce FSM with acceptance counter, optional auto-repeat counter and
// registered edge pulses.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   raw_i     in   asynchronous pin level (pin polarity)
//   stable_o  out  debounced level, 1 = active
//   rise_o    out  one-cycle pulse on accepted press / auto-repeat
//   fall_o    out  one-cycle pulse on accepted release
//   state_o   out  current FSM state (estado_t encoding)
//
// Latency: a raw change sampled at edge E is accepted at edge
// E + DEB_CYCLES + 1 (two synchronizer edges, then DEB_CYCLES edges with the
// normalized level differing from the accepted one).
// ---------------------------------------------------------------------------
module debounce_canal
  import painel_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_i,
  output logic       stable_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic [1:0] state_o
);

  localparam int   CW     = $clog2(DEB_CYCLES);
  localparam bit   REP_EN = (REPEAT_CYCLES > 0);
  // Pin level that means "not pressed"; the synchronizer resets to it so that
  // reset never looks like a press.
  localparam logic RAW_INACTIVE = ACTIVE_LOW ? 1'b1 : 1'b0;

  // -------------------------------------------------------------------------
  // Synchronizer
  // -------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RAW_INACTIVE;
      sync2_q <= RAW_INACTIVE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Normalized, synchronized level: 1 = active.
  logic s;
  assign s = normaliza(sync2_q, ACTIVE_LOW);

  // -------------------------------------------------------------------------
  // Debounce FSM state and counters
  // -------------------------------------------------------------------------
  estado_t        state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           stable_q, stable_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;
  logic           rep_hit;

  // -------------------------------------------------------------------------
  // Auto-repeat counter, only present when repeats are enabled.
  // It runs only while the channel is HELD and the level stays active, and
  // is cleared whenever the channel is anywhere else.
  // -------------------------------------------------------------------------
  if (REP_EN) begin : g_rep
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [RW-1:0] rcnt_q, rcnt_d;

    always_comb begin
      rcnt_d  = '0;
      rep_hit = 1'b0;
      if (state_q == ST_HELD && s) begin
        if (rcnt_q == RW'(REPEAT_CYCLES - 1)) begin
          rep_hit = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d  = rcnt_q + RW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rcnt_q <= '0;
      end else begin
        rcnt_q <= rcnt_d;
      end
    end
  end else begin : g_norep
    assign rep_hit = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The edge that first sees the difference is already the first
        // counted cycle, so the count starts at 1 on entry to COUNT.
        if (s != stable_q) begin
          state_d = ST_COUNT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end

      ST_COUNT: begin
        if (s == stable_q) begin
          // Glitch: level went back before acceptance, drop it entirely.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          stable_d = s;
          cnt_d    = '0;
          rise_d   = s;
          fall_d   = ~s;
          state_d  = (s && REP_EN) ? ST_HELD : ST_IDLE;
        end else begin
          cnt_d    = cnt_q + CW'(1);
        end
      end

      ST_HELD: begin
        if (!s) begin
          // Release path is timed exactly like a release from IDLE.
          state_d = ST_COUNT;
          cnt_d   = CW'(1);
        end else if (rep_hit) begin
          rise_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign state_o  = state_q;

endmodule

// File: rtl/debounce_entradas.sv
// ---------------------------------------------------------------------------
// debounce_entradas
// Front-panel input conditioner. Raw asynchronous panel levels in,
// synchronized debounced levels and one-cycle edge pulses out, all in the
// clk domain. One independent debounce_canal per input channel; the top only
// builds the port vectors and the any_rise OR.
//
// Ports:
//   clk  in  system clock (only clock)
//   rst  in  synchronous active-high reset
//   bus  debounce_entradas_if.slave:
//          raw (in), stable/rise/fall/any_rise/dbg_state (out)
//
// Parameters:
//   N_CH          number of channels (must match the interface N_CH)
//   DEB_CYCLES    acceptance time in cycles, >= 2
//   ACTIVE_LOW    1: pin reads 0 when pressed
//   REPEAT_CYCLES auto-repeat period while held, 0 disables repeats
// ---------------------------------------------------------------------------
module debounce_entradas
  import painel_pkg::*;
#(
  parameter int N_CH          = N_CH_DEF,
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  debounce_entradas_if.slave  bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_canal
    debounce_canal #(
      .DEB_CYCLES    (DEB_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_canal (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (bus.raw[i]),
      .stable_o (bus.stable[i]),
      .rise_o   (bus.rise[i]),
      .fall_o   (bus.fall[i]),
      .state_o  (bus.dbg_state[i])
    );
  end

  // rise is already registered per channel, so this OR lines up with it.
  assign bus.any_rise = |bus.rise;

endmodule
